aes_encrypt_core: RTL and testbench
===================================

# aes_encrypt_core

Iterative AES-128 encryption engine: accepts one 128-bit plaintext block over a valid/ready handshake and returns the ciphertext over a second valid/ready handshake. It computes one round per clock cycle from a pre-expanded 11-round key schedule produced by the team's KeyExpansion block. It is the forward-direction counterpart of the iterative decryption core and uses the same key-schedule bus layout.

## Interface
- `Nr`, default 10: number of rounds. Only 10 (AES-128) is supported.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` holds a plaintext block.
- `in_ready` output 1: the core can accept a block.
- `in_data` input 128: plaintext, byte 0 in bits [127:120].
- `all_keys` input 1408: round key r occupies `[128*(10-r)+127 : 128*(10-r)]`, so round key 0 is the MSB slice.
- `out_valid` output 1: `out_data` holds a valid ciphertext block.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_data` output 128: ciphertext, same byte order as `in_data`.
- `busy` output 1: the core is in the ROUND state.

## Operation
- The FSM has three states: IDLE, ROUND, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: state ← `in_data` ^ round key 0, round counter ← 1, go to ROUND.
- **ROUND**
  - One round per cycle.
  - For counter 1..Nr-1: state ← MixColumns(ShiftRows(SubBytes(state))) ^ key[counter], then counter increments.
  - For counter Nr: state ← ShiftRows(SubBytes(state)) ^ key[Nr], then go to DONE.
- **DONE**
  - `out_valid`=1 and `out_data`=state; both hold stable until `out_ready`=1.
  - On `out_valid && out_ready`: go to IDLE.
- `in_ready` is low in ROUND and DONE. A block is never accepted in the same cycle as an output transfer.
- The counter is 4 bits and never exceeds Nr. In IDLE its value is don't-care, but it is reset to 0.
- `in_data` is sampled only on the acceptance edge. Changing it afterwards has no effect.
- The key source depends on `AES_ENC_KEY_LATCH_EN` (see Configuration).

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`=1, `out_valid`=0, `out_data`=128'h0, `busy`=0, round counter = 0.
- Reset takes effect immediately when asserted, including mid-operation. The block in flight is discarded and no `out_valid` pulse occurs.
- Latency: acceptance on edge E0 gives `out_valid`=1 after edge E0+Nr (10 cycles). `busy` is high for exactly Nr cycles.
- Throughput with `out_ready` tied high: one block per Nr+2 cycles. The extra cycles are the DONE transfer and the return to IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Backpressure: `out_ready`=0 in DONE holds the state indefinitely, and `out_data` does not change.

## Configuration
- Macro: `AES_ENC_KEY_LATCH_EN`.
- Defined:
  - On acceptance the core copies `all_keys` into an internal 1408-bit register and uses it for all rounds.
  - `all_keys` may change any time after the acceptance edge.
- Undefined:
  - No key register; rounds index `all_keys` directly.
  - `all_keys` must remain stable from acceptance until `out_valid`. Behaviour is undefined if it changes.
- Cycle timing is identical in both builds.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rises exactly 10 cycles after acceptance.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` is stable, `in_ready`=0 throughout, and an `in_valid` pulse is ignored. Then `out_ready`=1 for one cycle -> `out_valid` drops and `in_ready`=1 the next cycle.
- Back-to-back: `in_valid` and `out_ready` held high with the two vectors above -> both correct ciphertexts appear in order, and acceptances are 12 cycles apart.
- Reset mid-round: assert `rst_n`=0 at round 5 -> outputs take their reset values immediately, and no `out_valid` appears after release. A new block then encrypts correctly.
- With `AES_ENC_KEY_LATCH_EN`: corrupt `all_keys` to all-zero one cycle after acceptance -> the C.1 result is still produced.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock from a pre-expanded key schedule.
// Define AES_ENC_KEY_LATCH_EN to capture the key schedule at block acceptance.
module aes_encrypt_core #(
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    input  logic [128*(Nr+1)-1:0]   all_keys,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data,
    output logic                    busy
);

    localparam int KW = 128 * (Nr + 1);
    localparam logic [3:0] LAST = 4'(Nr);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    state_t         st;
    logic [127:0]   blk;
    logic [3:0]     cnt;
    logic [127:0]   rk;
    logic [127:0]   sr;
    logic [127:0]   nxt;
    logic [KW-1:0]  key_src;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Byte b sits at bit offset 2047-8*b in the packed table.
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

`ifdef AES_ENC_KEY_LATCH_EN
    logic [KW-1:0] key_q;
    assign key_src = key_q;
`else
    assign key_src = all_keys;
`endif

    always_comb begin
        rk = '0;
        for (int r = 0; r <= Nr; r++)
            if (cnt == 4'(r))
                rk = key_src[128*(Nr-r) +: 128];
    end

    always_comb begin
        sr  = shift_rows(sub_bytes(blk));
        nxt = (cnt == LAST) ? (sr ^ rk) : (mix_columns(sr) ^ rk);
    end

    assign out_data = blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            blk       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_ENC_KEY_LATCH_EN
            key_q     <= '0;
`endif
        end else begin
            unique case (st)
                IDLE: begin
                    if (in_valid) begin
                        blk      <= in_data ^ all_keys[KW-1 -: 128];
                        cnt      <= 4'd1;
                        st       <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef AES_ENC_KEY_LATCH_EN
                        key_q    <= all_keys;
`endif
                    end
                end
                ROUND: begin
                    blk <= nxt;
                    if (cnt == LAST) begin
                        st        <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    st        <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core against a byte-level AES reference.
// Exercises AES_ENC_KEY_LATCH_EN key corruption when that macro is defined.
module tb_aes_encrypt_core;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [1407:0]  all_keys;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    int total = 0;
    int bad = 0;

    logic [7:0] sbm [256];

    always #5 clk = ~clk;

    aes_encrypt_core #(.Nr(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .all_keys  (all_keys),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, bx;
            inv = 8'h00;
            bx = 8'(x);
            for (int y = 1; y < 256; y++)
                if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
            sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                     ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1407:0] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbm[t[31:24]], sbm[t[23:16]], sbm[t[15:8]], sbm[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int r = 0; r <= 10; r++)
            ks[128*(10-r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1407:0] ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbm[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    s[4*c]   = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
                    s[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ ks[128*(10-rnd)+127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [1407:0] ks,
                             input logic [127:0] exp, input string tag,
                             input bit corrupt);
        int w, lat, nb;
        in_data = pt;
        all_keys = ks;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        check($sformatf("%s_ready", tag), in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data = rand128();
        lat = 0;
        nb = 0;
        while (!out_valid && lat < 30) begin
            if (busy) nb++;
            if (corrupt && lat == 1) all_keys = '0;
            tick();
            lat++;
        end
        check($sformatf("%s_latency", tag), lat, 10);
        check($sformatf("%s_busy_cycles", tag), nb, 10);
        check($sformatf("%s_out_valid", tag), out_valid, 1);
        check($sformatf("%s_data", tag), out_data, exp);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s_rel_valid", tag), out_valid, 0);
        check($sformatf("%s_rel_ready", tag), in_ready, 1);
    endtask

    initial begin
        logic [127:0] pt, key, exp, hold;
        logic [1407:0] ks, k_c1, k_b;
        logic [127:0] pts [2];
        logic [127:0] cts [2];
        logic [1407:0] kss [2];
        logic [127:0] outs [$];
        int acc [$];
        int idx, seen;

        build_sbox();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        all_keys = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        k_c1 = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        run_block(128'h00112233445566778899aabbccddeeff, k_c1,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1", 1'b0);
        release_out("c1");

        k_b = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_block(128'h3243f6a8885a308d313198a2e0370734, k_b,
                  128'h3925841d02dc09fbdc118597196a0b32, "fipsb", 1'b0);
        release_out("fipsb");

        for (int n = 0; n < 5; n++) begin
            key = rand128();
            pt = rand128();
            ks = key_expand(key);
            run_block(pt, ks, ref_enc(pt, ks), $sformatf("rnd%0d", n), 1'b0);
            release_out($sformatf("rnd%0d", n));
        end

        // Backpressure: output held, a stray in_valid pulse must be ignored.
        key = rand128();
        pt = rand128();
        ks = key_expand(key);
        exp = ref_enc(pt, ks);
        run_block(pt, ks, exp, "bp", 1'b0);
        hold = out_data;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_data = rand128();
            tick();
            check("bp_data", out_data, hold);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release_out("bp");
        tick();
        check("bp_no_accept", busy, 0);

        // Back-to-back with in_valid and out_ready held high.
        pts[0] = 128'h00112233445566778899aabbccddeeff;
        cts[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kss[0] = k_c1;
        pts[1] = 128'h3243f6a8885a308d313198a2e0370734;
        cts[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        kss[1] = k_b;
        idx = 0;
        in_data = pts[0];
        all_keys = kss[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && outs.size() < 2; cyc++) begin
            bit acc_now;
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) outs.push_back(out_data);
            if (out_valid && idx == 1) all_keys = kss[1];
            tick();
            if (acc_now) begin
                acc.push_back(cyc);
                idx++;
                if (idx < 2) in_data = pts[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_count", outs.size(), 2);
        check("b2b_acc_count", acc.size(), 2);
        if (outs.size() == 2) begin
            check("b2b_first", outs[0], cts[0]);
            check("b2b_second", outs[1], cts[1]);
        end
        if (acc.size() == 2)
            check("b2b_spacing", acc[1] - acc[0], 12);

        // Reset during round 5.
        key = rand128();
        pt = rand128();
        ks = key_expand(key);
        in_data = pt;
        all_keys = ks;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_no_out_valid", seen, 0);
        key = rand128();
        pt = rand128();
        ks = key_expand(key);
        run_block(pt, ks, ref_enc(pt, ks), "after_rst", 1'b0);
        release_out("after_rst");

`ifdef AES_ENC_KEY_LATCH_EN
        run_block(128'h00112233445566778899aabbccddeeff, k_c1,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, "latch", 1'b1);
        release_out("latch");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
